// File: rtl/unidade_controle_pkg.sv
// Shared game constants and state codes for the memory-game control unit.
// Display decoders and benches import these so every block agrees on the codes.
package unidade_controle_pkg;

    typedef enum logic [3:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        ESPERA_JOGADA     = 4'h2,
        REGISTRA          = 4'h4,
        COMPARACAO        = 4'h5,
        PROXIMA_JOGADA    = 4'h6,
        PROXIMA_SEQUENCIA = 4'h7,
        FIM_ACERTO        = 4'hA,
        FIM_TIMEOUT       = 4'hD,
        FIM_ERRO          = 4'hE
    } estado_t;

    // Cycles the player may spend on one play before the round is lost.
    localparam int unsigned CICLOS_TIMEOUT = 3000;

endpackage

// File: rtl/unidade_controle.sv
// Control FSM for the memory game: state register, next-state logic and a Moore output decode.
// Decision on a play lands three edges after jogada_feita; end states hold until iniciar.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       fim_sequencia,
    input  logic       ultima_sequencia,
    input  logic       jogada_feita,
    input  logic       fim_timer,
    input  logic       fimE,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zera_timer,
    output logic       conta_timer,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo;

    // The address terminal count is reported by the datapath but never steers the FSM.
    logic unused_fim_e;
    assign unused_fim_e = fimE;

    always_ff @(posedge clock) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:           proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:        proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita)
                    proximo = REGISTRA;
                else if (fim_timer)
                    proximo = FIM_TIMEOUT;
                else
                    proximo = ESPERA_JOGADA;
            end
            REGISTRA:          proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    proximo = FIM_ERRO;
                else if (fim_sequencia && ultima_sequencia)
                    proximo = FIM_ACERTO;
                else if (fim_sequencia)
                    proximo = PROXIMA_SEQUENCIA;
                else
                    proximo = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA:    proximo = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: proximo = ESPERA_JOGADA;
            FIM_ACERTO:        proximo = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:          proximo = iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT:       proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:           proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraC       = 1'b0;
        contaC      = 1'b0;
        zeraL       = 1'b0;
        contaL      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zera_timer  = 1'b0;
        conta_timer = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        timeout     = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC      = 1'b1;
                zeraL      = 1'b1;
                zeraR      = 1'b1;
                zera_timer = 1'b1;
            end
            ESPERA_JOGADA:  conta_timer = 1'b1;
            REGISTRA: begin
                registraR  = 1'b1;
                zera_timer = 1'b1;
            end
            PROXIMA_JOGADA: contaC = 1'b1;
            // New round: restart the address at 0 and grow the limit by one.
            PROXIMA_SEQUENCIA: begin
                contaL     = 1'b1;
                zeraC      = 1'b1;
                zera_timer = 1'b1;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule
